fifo_sync_param: RTL



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem_dp.sv | 28 ++
 rtl/fifo_sync_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO family.
package fifo_pkg;

  // Default geometry and almost-thresholds (24-bit x 16-entry).
  localparam int DEF_DATA_W    = 24;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_THRESH = 14;

  // Read-mode selectors for the FWFT parameter.
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Number of entries addressed by an addr_w-bit pointer.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [depth_of(ADDR_W)];

  // Store the incoming word at the write address; contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The head word must be visible without a clock for fall-through mode.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with configurable geometry, almost-flags, standard or
// first-word-fall-through read, synchronous flush and sticky error reporting.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int FWFT      = MODE_STD
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   data_count,
  output logic              empty,
  output logic              full,
  output logic              almst_empty,
  output logic              almst_full,
  output logic              overflow,
  output logic              underflow,
  output logic              err
);

  localparam int              DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_ovf;
  logic              r_udf;
  logic              r_err;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ovf_next;
  logic              w_udf_next;
  logic [DATA_W-1:0] w_head;

  // Flags come straight from the registered occupancy.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_CNT);

  // Acceptance uses this cycle's flags, so at full a read frees no room for a
  // same-cycle write, and at empty a same-cycle write cannot feed the read.
  assign w_wr_acc   = wr_en && !w_full;
  assign w_rd_acc   = rd_en && !w_empty;
  assign w_ovf_next = wr_en && w_full;
  assign w_udf_next = rd_en && w_empty;

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc && !clr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  // Advance pointers on accepted transfers and track occupancy; flush wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Standard-mode output register: captures the head word on an accepted read.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_dout <= '0;
    end else if (clr) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= w_head;
    end
  end

  // Registered one-cycle reject pulses and the sticky error they feed.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_err <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
      r_err <= r_err | w_ovf_next | w_udf_next;
    end
  end

  // Fall-through mode shows the head word directly, forced to zero when empty.
  always_comb begin
    data_out = r_dout;
    if (FWFT == MODE_FWFT) begin
      data_out = w_empty ? '0 : w_head;
    end
  end

  assign data_count  = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almst_empty = (r_count <= AE_CNT);
  assign almst_full  = (r_count >= AF_CNT);
  assign overflow    = r_ovf;
  assign underflow   = r_udf;
  assign err         = r_err;

endmodule
